// File: rtl/vm_job_scheduler.sv
// vm_job_scheduler: round-robin job launcher for one shared VM engine; optional instruction watchdog under VM_SCHED_WATCHDOG_EN
module vm_job_scheduler #(
  parameter int NREQ = 4,
  parameter int PC_W = 16,
  parameter int POS_W = 16,
  parameter int CNT_W = 24,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*PC_W-1:0]  req_pc,
  input  logic [NREQ*POS_W-1:0] req_pos,
  output logic                  vm_start,
  output logic [PC_W-1:0]       vm_pc,
  output logic [POS_W-1:0]      vm_pos,
  input  logic                  vm_instr,
  input  logic                  vm_done,
  input  logic                  vm_matched,
  input  logic [POS_W-1:0]      vm_end_pos,
  output logic                  vm_abort,
  input  logic [CNT_W-1:0]      cfg_max_instr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_matched,
  output logic [POS_W-1:0]      rsp_pos,
  output logic                  rsp_timeout
);
`ifdef VM_SCHED_WATCHDOG_EN
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ABORT, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, RESP} state_t;
`endif
  state_t state, state_nx;
  logic [ID_W-1:0] last, gnt_idx, rr_j;
  logic gnt_any;
  // round-robin search; later iterations are closer to last and override, so the nearest requester after last wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_j = ID_W'((int'(last) + k) % NREQ);
      if (req_valid[rr_j]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_j;
      end
    end
  end
`ifdef VM_SCHED_WATCHDOG_EN
  logic [CNT_W-1:0] cnt;
  logic wd_hit;
  assign wd_hit = (cfg_max_instr != '0) && (cnt >= cfg_max_instr);
  // instruction budget counter: cleared at launch, saturating while running
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == LAUNCH) cnt <= '0;
    else if (state == RUN && vm_instr && cnt != '1) cnt <= cnt + 1'b1;
`else
  logic unused_wd;
  assign unused_wd = ^{cfg_max_instr, vm_instr};
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and handshake/strobe outputs; req_ready is gated by rst_n so it stays low during reset
  always_comb begin
    state_nx = state;
    req_ready = '0;
    vm_start = 1'b0;
    vm_abort = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: if (gnt_any) begin
        req_ready[gnt_idx] = rst_n;
        state_nx = LAUNCH;
      end
      LAUNCH: begin
        vm_start = 1'b1;
        state_nx = RUN;
      end
      RUN: if (vm_done) state_nx = RESP;
`ifdef VM_SCHED_WATCHDOG_EN
      else if (wd_hit) state_nx = ABORT;
      ABORT: begin
        vm_abort = 1'b1;
        state_nx = RESP;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        state_nx = rsp_ready ? IDLE : RESP;
      end
      default: state_nx = IDLE;
    endcase
  end
  // capture granted requester and its operands; vm_pc/vm_pos double as the job's start operands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= ID_W'(NREQ - 1);
      rsp_id <= '0;
      vm_pc <= '0;
      vm_pos <= '0;
    end else if (state == IDLE && gnt_any) begin
      last <= gnt_idx;
      rsp_id <= gnt_idx;
      vm_pc <= req_pc[int'(gnt_idx)*PC_W +: PC_W];
      vm_pos <= req_pos[int'(gnt_idx)*POS_W +: POS_W];
    end
  // response payload: VM result on completion, start position on abort or no match
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_matched <= 1'b0;
      rsp_pos <= '0;
    end else if (state == RUN && vm_done) begin
      rsp_matched <= vm_matched;
      rsp_pos <= vm_matched ? vm_end_pos : vm_pos;
    end
`ifdef VM_SCHED_WATCHDOG_EN
    else if (state == ABORT) begin
      rsp_matched <= 1'b0;
      rsp_pos <= vm_pos;
    end
  // timeout flag marks responses produced by the watchdog
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp_timeout <= 1'b0;
    else if (state == RUN && vm_done) rsp_timeout <= 1'b0;
    else if (state == ABORT) rsp_timeout <= 1'b1;
`else
  assign rsp_timeout = 1'b0;
`endif
endmodule
